nco_tick_gen: RTL

- Numerically-controlled tick generator running on the PLL-derived system clock.
- Derives slow, fractionally-accurate clock-enable strobes (UART baud, VGA pixel, timer ticks) from clk, plus a 50%-duty square-wave enable that toggles on each tick.
- A phase accumulator adds a programmable increment every enabled cycle; each carry-out is one tick.
- Increment updates use a valid/ready handshake and take effect only at a tick boundary, so tick spacing never glitches.

---
 rtl/periph_pkg.sv | 18 +
 rtl/nco_acc.sv | 38 +++
 rtl/nco_tick_gen.sv | 94 +++++++++
 3 files changed

// File: rtl/periph_pkg.sv
// Shared peripheral definitions: NCO FSM encoding, common increments and a rate helper.
package periph_pkg;

  localparam logic [1:0] ST_STOP = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_PEND = 2'd2;

  // 32-bit increments for a 50 MHz clock, rounded to nearest.
  localparam logic [31:0] BAUD_115200_INC = 32'd9895605;
  localparam logic [31:0] PIX_25M_INC     = 32'h8000_0000;

  function automatic longint unsigned inc_for(input longint unsigned f_out,
                                              input longint unsigned f_clk,
                                              input int unsigned     acc_w);
    return ((f_out << acc_w) + (f_clk >> 1)) / f_clk;
  endfunction

endpackage

// File: rtl/nco_acc.sv
// Phase accumulator: adds inc every enabled cycle, registers the carry as a tick.
module nco_acc
  import periph_pkg::*;
#(
  parameter int unsigned ACC_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sync_clear,
  input  logic [ACC_W-1:0] inc,
  output logic             carry,
  output logic             tick
);

  logic [ACC_W-1:0] acc;
  logic [ACC_W:0]   sum;

  assign sum   = {1'b0, acc} + {1'b0, inc};
  assign carry = sum[ACC_W];

  // A clear wins over a coincident carry, so resynchronising never emits a tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc  <= '0;
      tick <= 1'b0;
    end else if (sync_clear) begin
      acc  <= '0;
      tick <= 1'b0;
    end else if (en) begin
      acc  <= sum[ACC_W-1:0];
      tick <= carry;
    end else begin
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/nco_tick_gen.sv
// NCO tick generator: fractional-rate tick strobe, square wave, tick counter and
// an increment update path that only takes effect on a tick boundary.
module nco_tick_gen
  import periph_pkg::*;
#(
  parameter int unsigned       ACC_W       = 32,
  parameter int unsigned       CNT_W       = 16,
  parameter logic [ACC_W-1:0]  DEFAULT_INC = {1'b1, {(ACC_W-1){1'b0}}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sync_clear,
  input  logic [ACC_W-1:0] inc_data,
  input  logic             inc_valid,
  output logic             inc_ready,
  output logic             tick,
  output logic             sq_out,
  output logic [CNT_W-1:0] tick_count,
  output logic             running,
  output logic [1:0]       fsm_state
);

  // Handshake: a new increment transfers on any rising edge where inc_valid and
  // inc_ready are both high; inc_ready is low only while a value waits in PEND.

  logic [ACC_W-1:0] inc_q;
  logic [ACC_W-1:0] pend_inc;
  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic             carry;
  logic             hs;
  logic             tick_set;
  logic             pend_apply;

  nco_acc #(.ACC_W(ACC_W)) u_acc (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .sync_clear (sync_clear),
    .inc        (inc_q),
    .carry      (carry),
    .tick       (tick)
  );

  assign inc_ready  = (state != ST_PEND);
  assign running    = (state != ST_STOP);
  assign fsm_state  = state;
  assign hs         = inc_valid & inc_ready;
  assign tick_set   = en & carry & ~sync_clear;
  // Pending value lands on a carry, or at once when the accumulator stops or is cleared.
  assign pend_apply = (state == ST_PEND) & (~en | sync_clear | carry);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_STOP: if (en) state_nxt = ST_RUN;
      ST_RUN: begin
        if (!en)     state_nxt = ST_STOP;
        else if (hs) state_nxt = ST_PEND;
      end
      ST_PEND: if (pend_apply) state_nxt = en ? ST_RUN : ST_STOP;
      default: state_nxt = ST_STOP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_STOP;
      inc_q    <= DEFAULT_INC;
      pend_inc <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_PEND) begin
        if (pend_apply) inc_q <= pend_inc;
      end else if (hs) begin
        // While the accumulator runs, defer the change to the next tick boundary.
        if (state == ST_RUN && en) pend_inc <= inc_data;
        else                       inc_q    <= inc_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tick_count <= '0;
      sq_out     <= 1'b0;
    end else if (tick_set) begin
      tick_count <= tick_count + CNT_W'(1);
      sq_out     <= ~sq_out;
    end
  end

endmodule
